// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types for the register-file write-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, PEND, FORCE)
//   entry_t     : one queued mul/div result {live, wa, wd}
//   REG_ZERO    : architectural zero register, never written
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        FORCE
    } arb_state_e;

    typedef struct packed {
        logic        live;
        logic [4:0]  wa;
        logic [31:0] wd;
    } entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bus bundle between the pipeline / mul-div unit and the
// register-file write-port arbiter.
//   pipe_we/pipe_wa/pipe_wd : writeback stage write request
//   md_valid/md_wa/md_wd    : mul/div result offer, md_ready = FIFO not full
//   rf_we/rf_wa/rf_wd       : register-file write port (registered)
//   stall_req               : freeze IF..MEM so queued results can drain
//   md_pending              : at least one live queued mul/div result
// Modports: master = requesters/consumers side, slave = arbiter side.
interface wb_port_arbiter_if;

    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        md_valid;
    logic [4:0]  md_wa;
    logic [31:0] md_wd;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        stall_req;
    logic        md_pending;

    modport master (
        output pipe_we, pipe_wa, pipe_wd, md_valid, md_wa, md_wd,
        input  md_ready, rf_we, rf_wa, rf_wd, stall_req, md_pending
    );

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd, md_valid, md_wa, md_wd,
        output md_ready, rf_we, rf_wa, rf_wd, stall_req, md_pending
    );

endinterface

// File: rtl/wb_arb_fifo.sv
// wb_arb_fifo: small circular FIFO of mul/div results with per-entry kill.
//   clk, rst_n      : clock, asynchronous active-low reset (empties FIFO)
//   push/push_entry : enqueue at tail (caller guarantees not full)
//   pop             : dequeue head (caller guarantees not empty)
//   kill/kill_wa    : clear live on every stored entry with wa == kill_wa;
//                     an entry pushed in the same cycle is not affected
//   head            : current head entry (valid when !empty)
//   full/empty      : occupancy flags; empty_next = empty after this cycle
//   any_live        : at least one stored entry is still live
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  entry_t     push_entry,
    input  logic       pop,
    input  logic       kill,
    input  logic [4:0] kill_wa,
    output entry_t     head,
    output logic       full,
    output logic       empty,
    output logic       empty_next,
    output logic       any_live
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].wa == kill_wa) begin
                        mem[i].live <= 1'b0;
                    end
                end
            end
            // Popped slots are marked dead so any_live only sees occupied entries.
            if (pop) begin
                mem[rd_ptr].live <= 1'b0;
                rd_ptr           <= rd_ptr + PTR_ONE;
            end
            // Written last so a same-cycle push is never killed.
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            cnt <= cnt + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
        end
    end

    always_comb begin
        any_live = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_live = any_live | mem[i].live;
        end
    end

    assign head       = mem[rd_ptr];
    assign full       = (cnt == CNT_FULL);
    assign empty      = (cnt == '0);
    assign empty_next = !push && (empty || ((cnt == CNT_ONE) && pop));

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage (always wins) and queued mul/div results.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : wb_port_arbiter_if.slave (pipe_*, md_*, rf_*, stall_req, md_pending)
// Parameters: DEPTH (FIFO entries, power of 2, >= 2),
//             STARVE_LIMIT (denied head cycles before stall_req, >= 1).
// Optional feature macro WB_ARB_BYPASS_EN: with an empty FIFO and no pipe
// request, a valid mul/div result goes straight to the port without queueing.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              rst_n,
    wb_port_arbiter_if.slave bus
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_ONE = CW'(1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic        pipe_req;
    logic        bypass;
    logic        push;
    logic        pop;
    logic        grant_head;
    entry_t      push_entry;
    entry_t      head;
    logic        full;
    logic        empty;
    logic        empty_next;
    logic        any_live;

    logic        we_d;
    logic [4:0]  wa_d;
    logic [31:0] wd_d;

    arb_state_e  state_q;
    logic [CW-1:0] starve_q;
    logic        stall_q;
    logic        rf_we_q;
    logic [4:0]  rf_wa_q;
    logic [31:0] rf_wd_q;

    assign pipe_req = bus.pipe_we && (bus.pipe_wa != REG_ZERO);

`ifdef WB_ARB_BYPASS_EN
    assign bypass = empty && !pipe_req && bus.md_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push       = bus.md_valid && !full && !bypass;
    assign grant_head = !empty && head.live && !pipe_req;
    // Dead heads leave without the port, even while the pipe owns it.
    assign pop        = !empty && (!head.live || !pipe_req);

    always_comb begin
        push_entry      = '0;
        push_entry.live = (bus.md_wa != REG_ZERO);
        push_entry.wa   = bus.md_wa;
        push_entry.wd   = bus.md_wd;
    end

    wb_arb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .kill      (pipe_req),
        .kill_wa   (bus.pipe_wa),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .empty_next(empty_next),
        .any_live  (any_live)
    );

    always_comb begin
        we_d = 1'b0;
        wa_d = rf_wa_q;
        wd_d = rf_wd_q;
        if (pipe_req) begin
            we_d = 1'b1;
            wa_d = bus.pipe_wa;
            wd_d = bus.pipe_wd;
        end else if (grant_head) begin
            we_d = 1'b1;
            wa_d = head.wa;
            wd_d = head.wd;
        end else if (bypass && (bus.md_wa != REG_ZERO)) begin
            we_d = 1'b1;
            wa_d = bus.md_wa;
            wd_d = bus.md_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            stall_q  <= 1'b0;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            rf_we_q <= we_d;
            rf_wa_q <= wa_d;
            rf_wd_q <= wd_d;
            if (empty_next) begin
                state_q  <= IDLE;
                starve_q <= '0;
                stall_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= PEND;
                        starve_q <= '0;
                    end
                    PEND: begin
                        // In PEND a head that is not popped was live and denied.
                        if (pop) begin
                            starve_q <= '0;
                        end else if (starve_q + STARVE_ONE == STARVE_MAX) begin
                            state_q  <= FORCE;
                            starve_q <= '0;
                            stall_q  <= 1'b1;
                        end else begin
                            starve_q <= starve_q + STARVE_ONE;
                        end
                    end
                    FORCE: begin
                        stall_q <= 1'b1;
                    end
                    default: begin
                        state_q  <= IDLE;
                        starve_q <= '0;
                        stall_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wa      = rf_wa_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.stall_req  = stall_q;
    assign bus.md_ready   = !full;
    assign bus.md_pending = any_live;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus for wb_port_arbiter, checked
// against a queue-based reference model of the port-sharing rules.
module tb_wb_port_arbiter;

    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        live;
        bit [4:0]  wa;
        bit [31:0] wd;
    } ent_t;

    // Reference model state.
    ent_t        q[$];
    bit          m_we;
    bit [4:0]    m_wa;
    bit [31:0]   m_wd;
    bit          m_stall;
    int unsigned m_starve;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit pend;
        pend = 1'b0;
        foreach (q[i]) if (q[i].live) pend = 1'b1;
        check_eq("rf_we", 32'(bus.rf_we), 32'(m_we));
        if (m_we) begin
            check_eq("rf_wa", 32'(bus.rf_wa), 32'(m_wa));
            check_eq("rf_wd", bus.rf_wd, m_wd);
        end
        check_eq("stall_req", 32'(bus.stall_req), 32'(m_stall));
        check_eq("md_pending", 32'(bus.md_pending), 32'(pend));
        check_eq("md_ready", 32'(bus.md_ready), 32'(q.size() < DEPTH));
    endtask

    // Drive one cycle of inputs at a negedge, advance the model, check at next negedge.
    task automatic step(input bit pwe, input bit [4:0] pwa, input bit [31:0] pwd,
                        input bit mv, input bit [4:0] mwa, input bit [31:0] mwd);
        bit preq, full, popped, byp;
        int had;
        bus.pipe_we  = pwe;
        bus.pipe_wa  = pwa;
        bus.pipe_wd  = pwd;
        bus.md_valid = mv;
        bus.md_wa    = mwa;
        bus.md_wd    = mwd;

        preq   = pwe && (pwa != 5'd0);
        full   = (q.size() >= DEPTH);
        had    = q.size();
        popped = 1'b0;
        byp    = 1'b0;
        m_we   = 1'b0;
        if (preq) begin
            m_we = 1'b1;
            m_wa = pwa;
            m_wd = pwd;
        end
        if (q.size() > 0) begin
            if (!q[0].live) begin
                void'(q.pop_front());
                popped = 1'b1;
            end else if (!preq) begin
                m_we = 1'b1;
                m_wa = q[0].wa;
                m_wd = q[0].wd;
                void'(q.pop_front());
                popped = 1'b1;
            end
        end
`ifdef WB_ARB_BYPASS_EN
        else if (!preq && mv) begin
            byp = 1'b1;
            if (mwa != 5'd0) begin
                m_we = 1'b1;
                m_wa = mwa;
                m_wd = mwd;
            end
        end
`endif
        if (preq) foreach (q[i]) if (q[i].wa == pwa) q[i].live = 1'b0;
        if (mv && !full && !byp) q.push_back('{live: (mwa != 5'd0), wa: mwa, wd: mwd});

        // Stall after STARVE_LIMIT consecutive denied head cycles, until the queue drains.
        if (q.size() == 0) begin
            m_starve = 0;
            m_stall  = 1'b0;
        end else if (popped) begin
            m_starve = 0;
        end else if (had > 0) begin
            m_starve++;
            if (m_starve >= STARVE_LIMIT) m_stall = 1'b1;
        end

        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.pipe_we  = 1'b0;
        bus.pipe_wa  = 5'd0;
        bus.pipe_wd  = 32'd0;
        bus.md_valid = 1'b1;
        bus.md_wa    = 5'd9;
        bus.md_wd    = 32'hDEAD_BEEF;
        #3;
        check_eq("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check_eq("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
        check_eq("rst_rf_wd", bus.rf_wd, 32'd0);
        check_eq("rst_stall", 32'(bus.stall_req), 32'd0);
        check_eq("rst_pending", 32'(bus.md_pending), 32'd0);
        check_eq("rst_ready", 32'(bus.md_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        bus.md_valid = 1'b0;
        rst_n        = 1'b1;
        q.delete();
        m_we     = 1'b0;
        m_stall  = 1'b0;
        m_starve = 0;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        do_reset();

        // Pipe write lands one cycle later; md result goes through the queue.
        step(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        check_eq("t2_pipe_wa", 32'(bus.rf_wa), 32'd5);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hAA);
        idle();
        idle();

        // WAW: a later pipe write to r7 kills the queued r7 result.
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77);
        step(1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'd0);
        check_eq("t3_pending", 32'(bus.md_pending), 32'd0);
        idle();
        idle();

        // Starvation: queued result denied by continuous pipe writes.
        step(1'b1, 5'd3, 32'h30, 1'b1, 5'd12, 32'hC0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 5'd3, 32'h31 + i, 1'b0, 5'd0, 32'd0);
            if (i == STARVE_LIMIT - 1) check_eq("t4_stall", 32'(bus.stall_req), 32'd1);
        end
        idle();
        check_eq("t4_md_write", 32'(bus.rf_wa), 32'd12);
        idle();

        // Fill under pipe writes, offer one more while full, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 5'd3, 32'h40 + i, 1'b1, 5'(10 + i), 32'h100 + i);
        check_eq("t5_full", 32'(bus.md_ready), 32'd0);
        step(1'b1, 5'd3, 32'h50, 1'b1, 5'd20, 32'h200);
        for (int i = 0; i < DEPTH + 2; i++) idle();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(1 + i), 32'h300 + i);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();

        // Register 0 is never written.
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        check_eq("t6_we_a", 32'(bus.rf_we), 32'd0);
        idle();
        check_eq("t6_we_b", 32'(bus.rf_we), 32'd0);
        check_eq("t6_ready", 32'(bus.md_ready), 32'd1);

        // Random traffic with a reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
